// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch initiator for a combinationally read instruction memory.
// Owns the fetch PC, issues at most one read per cycle, buffers returned words
// together with their PCs in a small circular queue, and hands them to the
// IF/ID stage over a valid/ready handshake. A redirect from EX flushes the
// queue and restarts fetch at the new (word-aligned) target.
//
// Ports
//   clk             in   1     rising-edge clock
//   rst             in   1     asynchronous, active-high reset
//   imem_req        out  1     read strobe; word on imem_rdata is captured this cycle
//   imem_addr       out  XLEN  byte address to instruction memory (= fetch PC)
//   imem_rdata      in   XLEN  instruction word, combinational from imem_addr
//   redirect_valid  in   1     taken branch/jump this cycle
//   redirect_pc     in   XLEN  redirect target; bits [1:0] are ignored
//   id_valid        out  1     queue head holds an instruction
//   id_ready        in   1     IF/ID accepts the head this cycle
//   id_instr        out  XLEN  head instruction, 0 when id_valid=0
//   id_pc           out  XLEN  PC of head instruction, 0 when id_valid=0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue occupancy class; the occupancy counter is the state register.
    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_PARTIAL,
        Q_FULL
    } q_state_t;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    q_state_t         q_state;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  redirect_target;

    // Masking instead of slicing keeps every bit of redirect_pc in use.
    assign redirect_target = redirect_pc & ~XLEN'(3);

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        q_state  = Q_PARTIAL;
        id_valid = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        imem_req = 1'b0;
        id_instr = '0;
        id_pc    = '0;

        if (count == '0) begin
            q_state = Q_EMPTY;
        end else if (count == FULL_CNT) begin
            q_state = Q_FULL;
        end

        id_valid = (q_state != Q_EMPTY);
        pop      = id_valid & id_ready;

        // A full queue can still accept a word when the head leaves this cycle.
        imem_req = ~rst & ~redirect_valid & ((q_state != Q_FULL) | pop);
        push     = imem_req;

        if (id_valid) begin
            id_instr = instr_q[rd_ptr];
            id_pc    = pc_q[rd_ptr];
        end
    end

    assign imem_addr = fetch_pc;

    // -------------------------------------------------------------------------
    // Queue storage
    // -------------------------------------------------------------------------
    // NOTE: the data array has no reset; validity is tracked solely by count,
    // so stale contents are never visible and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

    // -------------------------------------------------------------------------
    // Control state: fetch PC, pointers, occupancy
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            // Flush everything; a head handshaken this cycle is simply gone
            // along with the rest, which is exactly "consumed".
            fetch_pc <= redirect_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
